// File: rtl/seg_dynamic.sv
// -----------------------------------------------------------------------------
// seg_dynamic
//
// Six-digit multiplexed seven-segment driver feeding a 74HC595 shift
// controller. A free-running double-dabble engine converts the 20-bit input
// to six BCD digits (saturating at 999_999). A scan counter then presents one
// digit per slot as a one-hot select plus an active-low segment pattern.
//
// Parameters:
//   CNT_MAX   scan-slot length minus one, in sys_clk cycles (minimum 2)
//
// Ports:
//   sys_clk   in   system clock, all registers on the rising edge
//   sys_rst   in   synchronous, active-high reset
//   data      in   [19:0] unsigned value to display
//   point     in   [5:0]  decimal-point enables, bit 0 = rightmost digit
//   seg_en    in   display enable, 0 blanks sel/seg at the next slot
//   sel       out  [5:0]  one-hot digit select, active-high, registered
//   seg       out  [7:0]  {dp,g,f,e,d,c,b,a}, active-low, registered
//   busy      out  high while a conversion is in LOAD or SHIFT
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits (never digit 0)
//                          are blanked; their DP still follows point.
// -----------------------------------------------------------------------------
module seg_dynamic #(
  parameter int CNT_MAX = 49_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        seg_en,
  output logic [5:0]  sel,
  output logic [7:0]  seg,
  output logic        busy
);

  localparam int          CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [19:0] VAL_MAX = 20'd999_999;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [23:0] bcd_adjust(input logic [23:0] b);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    end
    return r;
  endfunction

  // Active-low a..g pattern for one BCD digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h40;
      4'd1:    p = 7'h79;
      4'd2:    p = 7'h24;
      4'd3:    p = 7'h30;
      4'd4:    p = 7'h19;
      4'd5:    p = 7'h12;
      4'd6:    p = 7'h02;
      4'd7:    p = 7'h78;
      4'd8:    p = 7'h00;
      4'd9:    p = 7'h10;
      default: p = 7'h7F;
    endcase
    return p;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Digit i is blanked when it and every digit above it are zero.
  function automatic logic [5:0] blank_mask(input logic [23:0] b);
    logic [5:0] m;
    logic       upper_zero;
    m          = '0;
    upper_zero = 1'b1;
    for (int i = 5; i >= 1; i--) begin
      upper_zero = upper_zero && (b[4*i +: 4] == 4'd0);
      m[i]       = upper_zero;
    end
    return m;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Conversion engine
  // ---------------------------------------------------------------------------
  state_t      state;
  logic [4:0]  bit_cnt;
  logic [19:0] bin;
  logic [23:0] bcd;
  logic [23:0] bcd_adj;
  logic [23:0] disp;
`ifdef LEADING_ZERO_BLANK_EN
  logic [5:0]  blank;
`endif

  // NOTE: combinational blocks assign every output unconditionally so that no
  // latch is inferred.
  always_comb begin
    bcd_adj = bcd_adjust(bcd);
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      // NOTE: the display register is reset, unlike a RAM, because an aborted
      // conversion must never leave the previous value visible.
      state   <= LOAD;
      bit_cnt <= '0;
      bin     <= '0;
      bcd     <= '0;
      disp    <= '0;
      busy    <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank   <= 6'b111110;   // consistent with an all-zero display register
`endif
    end else begin
      case (state)
        LOAD: begin
          bin     <= (data > VAL_MAX) ? VAL_MAX : data;
          bcd     <= '0;
          bit_cnt <= '0;
          state   <= SHIFT;
          busy    <= 1'b1;
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj[22:0], bin, 1'b0};
          if (bit_cnt == 5'd19) begin
            state <= DONE;
            busy  <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        DONE: begin
          // Single write of all six digits: no partial value is ever visible.
          disp  <= bcd;
`ifdef LEADING_ZERO_BLANK_EN
          blank <= blank_mask(bcd);
`endif
          state <= LOAD;
          busy  <= 1'b1;
        end
        default: begin
          state <= LOAD;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Scan and output encode
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_1ms;
  logic [2:0]       idx;
  logic [2:0]       idx_nxt;
  logic             wrap;
  logic [3:0]       digit;
  logic [6:0]       pattern;

  always_comb begin
    wrap    = (cnt_1ms == CNT_W'(CNT_MAX));
    idx_nxt = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    digit   = disp[{idx_nxt, 2'b00} +: 4];
    pattern = seg7(digit);
`ifdef LEADING_ZERO_BLANK_EN
    if (blank[idx_nxt]) pattern = 7'h7F;
`endif
  end

  // sel/seg, point and seg_en are only touched on the wrap, so outputs stay
  // constant for a whole slot regardless of mid-slot input or display changes.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_1ms <= '0;
      idx     <= 3'd5;
      sel     <= 6'b000000;
      seg     <= 8'hFF;
    end else begin
      cnt_1ms <= wrap ? '0 : cnt_1ms + 1'b1;
      if (wrap) begin
        idx <= idx_nxt;
        if (seg_en) begin
          sel <= 6'd1 << idx_nxt;
          seg <= {~point[idx_nxt], pattern};
        end else begin
          sel <= 6'b000000;
          seg <= 8'hFF;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_dynamic.sv
// -----------------------------------------------------------------------------
// tb_seg_dynamic
//
// Scoreboard bench for seg_dynamic with CNT_MAX = 9 (10-cycle slots).
// Stimulus computes the expected sel/seg for future slots from a decimal
// reference model and queues them tagged with the slot number; a monitor
// pops and compares them as each slot is presented and also checks reset
// values and the busy duty cycle every cycle.
// -----------------------------------------------------------------------------
module tb_seg_dynamic;

  localparam int CNT_MAX = 9;
  localparam int SLOT    = CNT_MAX + 1;
  localparam int CONV    = 22;          // LOAD + 20 x SHIFT + DONE
  localparam int SETTLE  = 2 * CONV + 1;

  localparam logic [6:0] SEG_LUT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    int         slot;
    logic [5:0] sel;
    logic [7:0] seg;
  } exp_t;

  logic        sys_clk;
  logic        sys_rst;
  logic [19:0] data;
  logic [5:0]  point;
  logic        seg_en;
  logic [5:0]  sel;
  logic [7:0]  seg;
  logic        busy;

  exp_t exp_q[$];
  exp_t cur;
  bit   cur_valid = 1'b0;
  bit   mon_en    = 1'b0;
  int   cyc       = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;

  seg_dynamic #(.CNT_MAX(CNT_MAX)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .data    (data),
    .point   (point),
    .seg_en  (seg_en),
    .sel     (sel),
    .seg     (seg),
    .busy    (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Cycles since the last reset edge.
  always @(posedge sys_clk) begin
    if (sys_rst) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cyc %0d, t=%0t)", name, act, req, cyc, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: decimal arithmetic on the displayed value.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] exp_seg(input int value, input logic [5:0] p, input int idx);
    int         v;
    int         pw;
    logic [6:0] pat;
    v  = (value > 999_999) ? 999_999 : value;
    pw = 1;
    for (int i = 0; i < idx; i++) pw = pw * 10;
    pat = SEG_LUT[(v / pw) % 10];
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && v < pw) pat = 7'h7F;
`endif
    return {~p[idx], pat};
  endfunction

  // Conversion schedule: LOAD at phase 0, SHIFT at 1..20, DONE at 21.
  function automatic logic exp_busy(input int c);
    return (c != 0) && ((c % CONV) != CONV - 1);
  endfunction

  task automatic push_slots(input int value, input logic [5:0] p, input logic e,
                            input int first, input int n);
    exp_t x;
    for (int k = first; k < first + n; k++) begin
      int idx;
      idx    = (k - 1) % 6;
      x.slot = k;
      if (e) begin
        x.sel = 6'(1 << idx);
        x.seg = exp_seg(value, p, idx);
      end else begin
        x.sel = 6'b000000;
        x.seg = 8'hFF;
      end
      exp_q.push_back(x);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge sys_clk);
  endtask

  // Apply inputs mid-cycle, queue n slots once the change must be visible,
  // and return in the middle of the last queued slot.
  task automatic apply(input int d, input logic [5:0] p, input logic e,
                       input int settle, input int n);
    int s0;
    data   = 20'(d);
    point  = p;
    seg_en = e;
    s0     = (cyc + settle) / SLOT + 1;
    push_slots(d, p, e, s0, n);
    wait_cyc((s0 + n - 1) * SLOT + SLOT / 2);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge sys_clk) begin
    int slot;
    if (mon_en) begin
      slot = cyc / SLOT;
      check("busy", 32'(busy), 32'(exp_busy(cyc)));
      if (slot == 0) begin
        cur_valid = 1'b0;
        check("reset_sel", 32'(sel), 32'h00);
        check("reset_seg", 32'(seg), 32'hFF);
      end else begin
        if (cyc % SLOT == 0) begin
          cur_valid = 1'b0;
          while (exp_q.size() > 0 && exp_q[0].slot < slot) begin
            check("missed_slot", 32'(exp_q[0].slot), 32'(slot));
            void'(exp_q.pop_front());
          end
          if (exp_q.size() > 0 && exp_q[0].slot == slot) begin
            cur       = exp_q.pop_front();
            cur_valid = 1'b1;
          end
        end
        if (cur_valid) begin
          check("slot_sel", 32'(sel), 32'(cur.sel));
          check("slot_seg", 32'(seg), 32'(cur.seg));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int d;
    int guard;
    logic [5:0] p;

    sys_rst = 1'b1;
    data    = '0;
    point   = '0;
    seg_en  = 1'b1;
    repeat (3) @(negedge sys_clk);
    mon_en  = 1'b1;
    sys_rst = 1'b0;

    // Zero after reset: all six digits, two full scans plus a wrap.
    apply(0, 6'b000000, 1'b1, 0, 13);

    // Fixed patterns, including saturation and a small value.
    apply(123_456, 6'b000100, 1'b1, SETTLE, 7);
    apply(20'hFFFFF, 6'b000000, 1'b1, SETTLE, 6);
    apply(42, 6'b000000, 1'b1, SETTLE, 6);
    apply(999_999, 6'b111111, 1'b1, SETTLE, 6);
    apply(1_000_000, 6'b000001, 1'b1, SETTLE, 6);

    // Randomized values and decimal points, large and small.
    for (int i = 0; i < 6; i++) begin
      d = (i % 2 == 0) ? int'($urandom_range(0, 20'hFFFFF)) : int'($urandom_range(0, 999));
      p = 6'($urandom_range(0, 63));
      apply(d, p, 1'b1, SETTLE, 6);
    end

    // Display disable mid-slot, then re-enable.
    apply(654_321, 6'b010000, 1'b1, SETTLE, 6);
    apply(654_321, 6'b010000, 1'b0, 0, 3);
    apply(654_321, 6'b010000, 1'b1, 0, 7);

    // One-cycle reset during SHIFT: previous value must not reappear.
    apply(987_654, 6'b100001, 1'b1, SETTLE, 6);
    guard = 0;
    while ((cyc % CONV) != 5 && guard < 2 * CONV) begin
      @(negedge sys_clk);
      guard++;
    end
    exp_q.delete();
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    push_slots(0, 6'b100001, 1'b1, 1, 2);
    push_slots(987_654, 6'b100001, 1'b1, 3, 7);
    wait_cyc(9 * SLOT + SLOT / 2);

    @(negedge sys_clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
